// File: rtl/gpio_irq_pkg.sv
// Shared types and the offset decoder for the gpio_irq register window.
package gpio_irq_pkg;
  `include "gpio_irq_regs.vh"

  localparam int WIN_LSB = $clog2(WINDOW_BYTES);

  typedef enum logic [3:0] {
    SEL_OUT, SEL_DIR, SEL_IN, SEL_SET, SEL_CLR,
    SEL_TGL, SEL_RISE, SEL_FALL, SEL_IP, SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [WIN_LSB-1:0] off);
    case (off)
      OFF_OUT:  return SEL_OUT;
      OFF_DIR:  return SEL_DIR;
      OFF_IN:   return SEL_IN;
      OFF_SET:  return SEL_SET;
      OFF_CLR:  return SEL_CLR;
      OFF_TGL:  return SEL_TGL;
      OFF_RISE: return SEL_RISE;
      OFF_FALL: return SEL_FALL;
      OFF_IP:   return SEL_IP;
      default:  return SEL_NONE;
    endcase
  endfunction
endpackage

// File: rtl/gpio_irq_regs.vh
// Register offsets and window size of the gpio_irq block.
// The firmware header generator reads this file as well.
`ifndef GPIO_IRQ_REGS_VH
`define GPIO_IRQ_REGS_VH
localparam logic [5:0] OFF_OUT  = 6'h00;
localparam logic [5:0] OFF_DIR  = 6'h04;
localparam logic [5:0] OFF_IN   = 6'h08;
localparam logic [5:0] OFF_SET  = 6'h0C;
localparam logic [5:0] OFF_CLR  = 6'h10;
localparam logic [5:0] OFF_TGL  = 6'h14;
localparam logic [5:0] OFF_RISE = 6'h18;
localparam logic [5:0] OFF_FALL = 6'h1C;
localparam logic [5:0] OFF_IP   = 6'h20;
localparam int WINDOW_BYTES = 64;
`endif

// File: rtl/gpio_sync.sv
// WIDTH x STAGES flop chain used as the pin-input metastability synchroniser.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];

  always_comb begin
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (!rst) chain_q[i] <= '0;
      else      chain_q[i] <= chain_d[i];
    end
  end

  assign q = chain_q[STAGES-1];
endmodule

// File: rtl/gpio_irq.sv
// Memory-mapped GPIO with per-pin direction, atomic output ops and
// sticky edge-triggered interrupt flags on a shared tri-state bus.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int          N_PINS      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hffff0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  inout  wire  [31:0]       mem_data,
  inout  wire  [N_PINS-1:0] gpio_pins,
  output logic              irq
);
  logic [N_PINS-1:0] out_q, out_d, dir_q, dir_d;
  logic [N_PINS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [N_PINS-1:0] ip_q, ip_d, prev_q, prev_d;
  logic              irq_q, irq_d;
  logic [N_PINS-1:0] in_sync, wdata, edge_set;
  logic              win_hit;
  reg_sel_e          sel;
  logic [31:0]       rdata;

  assign win_hit = (mem_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign sel     = decode_off(mem_addr[WIN_LSB-1:0]);
  assign wdata   = mem_data[N_PINS-1:0];

  if (N_PINS < 32) begin : g_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^mem_data[31:N_PINS];
  end

  gpio_sync #(.WIDTH(N_PINS), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_pins),
    .q   (in_sync)
  );

  for (genvar k = 0; k < N_PINS; k++) begin : g_pin
    assign gpio_pins[k] = dir_q[k] ? 1'bz : out_q[k];
  end

  // The bus is only driven for a read that hits the window outside reset.
  assign mem_data = (rst && !mem_we && win_hit) ? rdata : 'z;

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_OUT:  rdata[N_PINS-1:0] = out_q;
      SEL_DIR:  rdata[N_PINS-1:0] = dir_q;
      SEL_IN:   rdata[N_PINS-1:0] = in_sync;
      SEL_RISE: rdata[N_PINS-1:0] = rise_q;
      SEL_FALL: rdata[N_PINS-1:0] = fall_q;
      SEL_IP:   rdata[N_PINS-1:0] = ip_q;
      default:  rdata = '0;
    endcase
  end

  // Edges are qualified with the enables and direction as they stood before this cycle's write.
  assign edge_set = dir_q & ((in_sync & ~prev_q & rise_q) | (~in_sync & prev_q & fall_q));

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    rise_d = rise_q;
    fall_d = fall_q;
    ip_d   = ip_q;
    prev_d = in_sync;
    if (mem_we && win_hit) begin
      case (sel)
        SEL_OUT:  out_d  = wdata;
        SEL_DIR:  dir_d  = wdata;
        SEL_SET:  out_d  = out_q | wdata;
        SEL_CLR:  out_d  = out_q & ~wdata;
        SEL_TGL:  out_d  = out_q ^ wdata;
        SEL_RISE: rise_d = wdata;
        SEL_FALL: fall_d = wdata;
        SEL_IP:   ip_d   = ip_q & ~wdata;
        default:  ;
      endcase
    end
    ip_d  = ip_d | edge_set;
    irq_d = |ip_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q  <= '0;
      dir_q  <= '1;
      rise_q <= '0;
      fall_q <= '0;
      ip_q   <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      ip_q   <= ip_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
endmodule
